// File: rtl/prei_md_pingpong_ctrl_pkg.sv
// Shared definitions for the prei/posi ping-pong stage scheduler.
// Default coordinate widths mirror the encoder-wide picture geometry defines.
package prei_md_pingpong_ctrl_pkg;

    localparam int PIC_X_WIDTH_DEF = 8;
    localparam int PIC_Y_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SWAP   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/prei_md_pingpong_ctrl_ctu_raster_cnt.sv
// Raster-order CTU coordinate counter: x runs 0..x_max, then y advances.
// `last` flags the final CTU of the picture at the current position.
module prei_md_pingpong_ctrl_ctu_raster_cnt
    import prei_md_pingpong_ctrl_pkg::*;
#(
    parameter int PIC_X_WIDTH = PIC_X_WIDTH_DEF,
    parameter int PIC_Y_WIDTH = PIC_Y_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PIC_X_WIDTH-1:0] x_max,
    input  logic [PIC_Y_WIDTH-1:0] y_max,
    input  logic                   clr,
    input  logic                   inc,
    output logic [PIC_X_WIDTH-1:0] x,
    output logic [PIC_Y_WIDTH-1:0] y,
    output logic                   last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (inc) begin
            if (x == x_max) begin
                x <= '0;
                // Past the final row the counter wraps back to the first one.
                y <= (y == y_max) ? '0 : y + PIC_Y_WIDTH'(1);
            end else begin
                x <= x + PIC_X_WIDTH'(1);
            end
        end
    end

    assign last = (x == x_max) && (y == y_max);

endmodule

// File: rtl/prei_md_pingpong_ctrl.sv
// Stage scheduler for the prei/posi intra-mode ping-pong buffers: prei fills
// bank sel with CTU k while posi drains bank !sel with CTU k-1, in lockstep.
module prei_md_pingpong_ctrl
    import prei_md_pingpong_ctrl_pkg::*;
#(
    parameter int PIC_X_WIDTH = PIC_X_WIDTH_DEF,
    parameter int PIC_Y_WIDTH = PIC_Y_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start_i,
    input  logic [PIC_X_WIDTH-1:0] ctu_x_max_i,
    input  logic [PIC_Y_WIDTH-1:0] ctu_y_max_i,
    output logic                   frame_done_o,
    output logic                   busy_o,
    output logic                   sel_mod_2_o,
    output logic                   prei_start_o,
    input  logic                   prei_done_i,
    output logic [PIC_X_WIDTH-1:0] prei_ctu_x_o,
    output logic [PIC_Y_WIDTH-1:0] prei_ctu_y_o,
    output logic                   posi_start_o,
    input  logic                   posi_done_i,
    output logic [PIC_X_WIDTH-1:0] posi_ctu_x_o,
    output logic [PIC_Y_WIDTH-1:0] posi_ctu_y_o,
    output logic                   err_o
);

    state_t                 state;
    logic [PIC_X_WIDTH-1:0] x_max_q;
    logic [PIC_Y_WIDTH-1:0] y_max_q;
    logic                   prei_act;
    logic                   posi_act;
    logic                   prei_fin;
    logic                   posi_fin;
    logic                   prei_last;

    logic prei_ok;
    logic posi_ok;
    logic prei_bad;
    logic posi_bad;
    logic prei_fin_nxt;
    logic posi_fin_nxt;
    logic next_prei_act;
    logic raster_clr;
    logic raster_inc;

    // A done pulse counts only while waiting on a unit started this stage
    // that has not already reported; anything else is a protocol error.
    always_comb begin
        prei_ok       = prei_done_i && (state == ST_WAIT) && prei_act && !prei_fin;
        posi_ok       = posi_done_i && (state == ST_WAIT) && posi_act && !posi_fin;
        prei_bad      = prei_done_i && !prei_ok;
        posi_bad      = posi_done_i && !posi_ok;
        prei_fin_nxt  = prei_fin || prei_ok;
        posi_fin_nxt  = posi_fin || posi_ok;
        next_prei_act = prei_act && !prei_last;
        raster_clr    = (state == ST_IDLE) && frame_start_i;
        raster_inc    = (state == ST_SWAP) && prei_act;
    end

    prei_md_pingpong_ctrl_ctu_raster_cnt #(
        .PIC_X_WIDTH (PIC_X_WIDTH),
        .PIC_Y_WIDTH (PIC_Y_WIDTH)
    ) u_prei_raster (
        .clk   (clk),
        .rst   (rst),
        .x_max (x_max_q),
        .y_max (y_max_q),
        .clr   (raster_clr),
        .inc   (raster_inc),
        .x     (prei_ctu_x_o),
        .y     (prei_ctu_y_o),
        .last  (prei_last)
    );

    // The stage index is implicit: stage 0 is the only one without posi,
    // stage N the only one without prei (entered once prei has handled the
    // last CTU), and a SWAP leaving a prei-less stage ends the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            x_max_q      <= '0;
            y_max_q      <= '0;
            prei_act     <= 1'b0;
            posi_act     <= 1'b0;
            prei_fin     <= 1'b0;
            posi_fin     <= 1'b0;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
            sel_mod_2_o  <= 1'b0;
            prei_start_o <= 1'b0;
            posi_start_o <= 1'b0;
            posi_ctu_x_o <= '0;
            posi_ctu_y_o <= '0;
            err_o        <= 1'b0;
        end else begin
            prei_start_o <= 1'b0;
            posi_start_o <= 1'b0;
            frame_done_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (frame_start_i) begin
                        x_max_q      <= ctu_x_max_i;
                        y_max_q      <= ctu_y_max_i;
                        sel_mod_2_o  <= 1'b0;
                        posi_ctu_x_o <= '0;
                        posi_ctu_y_o <= '0;
                        prei_fin     <= 1'b0;
                        posi_fin     <= 1'b0;
                        err_o        <= 1'b0;
                        busy_o       <= 1'b1;
                        prei_act     <= 1'b1;
                        posi_act     <= 1'b0;
                        prei_start_o <= 1'b1;
                        state        <= ST_LAUNCH;
                    end
                end

                ST_LAUNCH: begin
                    // An idle unit is treated as already finished.
                    prei_fin <= !prei_act;
                    posi_fin <= !posi_act;
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    prei_fin <= prei_fin_nxt;
                    posi_fin <= posi_fin_nxt;
                    if (prei_fin_nxt && posi_fin_nxt) begin
                        state <= ST_SWAP;
                    end
                end

                ST_SWAP: begin
                    sel_mod_2_o  <= !sel_mod_2_o;
                    posi_ctu_x_o <= prei_ctu_x_o;
                    posi_ctu_y_o <= prei_ctu_y_o;
                    prei_fin     <= 1'b0;
                    posi_fin     <= 1'b0;
                    if (!prei_act) begin
                        frame_done_o <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        prei_act     <= next_prei_act;
                        posi_act     <= 1'b1;
                        prei_start_o <= next_prei_act;
                        posi_start_o <= 1'b1;
                        state        <= ST_LAUNCH;
                    end
                end

                ST_DONE: begin
                    busy_o   <= 1'b0;
                    prei_act <= 1'b0;
                    posi_act <= 1'b0;
                    state    <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (prei_bad || posi_bad) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prei_md_pingpong_ctrl.sv
// Bench for the prei/posi ping-pong scheduler: table of frames plus random
// frames, checked against a raster-order model of the expected schedule.
module tb_prei_md_pingpong_ctrl;

    localparam int XW = 8;
    localparam int YW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start_i = 1'b0;
    logic [XW-1:0] ctu_x_max_i = '0;
    logic [YW-1:0] ctu_y_max_i = '0;
    logic          prei_done_i = 1'b0;
    logic          posi_done_i = 1'b0;
    logic          frame_done_o, busy_o, sel_mod_2_o, err_o;
    logic          prei_start_o, posi_start_o;
    logic [XW-1:0] prei_ctu_x_o, posi_ctu_x_o;
    logic [YW-1:0] prei_ctu_y_o, posi_ctu_y_o;

    prei_md_pingpong_ctrl #(
        .PIC_X_WIDTH (XW),
        .PIC_Y_WIDTH (YW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start_i (frame_start_i),
        .ctu_x_max_i   (ctu_x_max_i),
        .ctu_y_max_i   (ctu_y_max_i),
        .frame_done_o  (frame_done_o),
        .busy_o        (busy_o),
        .sel_mod_2_o   (sel_mod_2_o),
        .prei_start_o  (prei_start_o),
        .prei_done_i   (prei_done_i),
        .prei_ctu_x_o  (prei_ctu_x_o),
        .prei_ctu_y_o  (prei_ctu_y_o),
        .posi_start_o  (posi_start_o),
        .posi_done_i   (posi_done_i),
        .posi_ctu_x_o  (posi_ctu_x_o),
        .posi_ctu_y_o  (posi_ctu_y_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    typedef struct packed {
        int xm;
        int ym;
        int lat_p;       // 0 selects a random latency per stage
        int lat_q;
        int dup;         // repeat prei done in stage 1
        int poke;        // pulse frame_start_i during stage 2
        int abort;       // stage at which to assert rst, -1 for none
        int exp_starts;
        int exp_toggles;
        int exp_err;
    } vec_t;

    vec_t tbl [7];

    int checks   = 0;
    int failures = 0;

    // Reference model state: expected coordinate sequences and counters.
    logic [15:0] prei_q [$];
    logic [15:0] posi_q [$];
    int          prei_cnt, posi_cnt, toggles, stage_idx, n_exp;
    logic        prev_sel;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({frame_done_o, busy_o, sel_mod_2_o, prei_start_o, prei_ctu_x_o,
                    prei_ctu_y_o, posi_start_o, posi_ctu_x_o, posi_ctu_y_o, err_o});
    endfunction

    task automatic mon_step();
        logic [1:0] exp_u;
        if (!mon_en) return;
        if (sel_mod_2_o !== prev_sel) toggles++;
        prev_sel = sel_mod_2_o;
        if (prei_start_o || posi_start_o) begin
            exp_u = (stage_idx == 0) ? 2'b10 : ((stage_idx == n_exp) ? 2'b01 : 2'b11);
            chk("launch_units", 64'({prei_start_o, posi_start_o}), 64'(exp_u));
            chk("launch_sel", 64'(sel_mod_2_o), 64'(stage_idx % 2));
            stage_idx++;
        end
        if (prei_start_o) begin
            prei_cnt++;
            if (prei_q.size() > 0)
                chk("prei_xy", 64'({prei_ctu_x_o, prei_ctu_y_o}), 64'(prei_q.pop_front()));
        end
        if (posi_start_o) begin
            posi_cnt++;
            if (posi_q.size() > 0)
                chk("posi_xy", 64'({posi_ctu_x_o, posi_ctu_y_o}), 64'(posi_q.pop_front()));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon_step();
    endtask

    task automatic run_frame(input vec_t v);
        int   lat_p, lat_q, tmax, stage;
        logic p, q, dup_now, nd;
        tick();
        ctu_x_max_i   = XW'(v.xm);
        ctu_y_max_i   = YW'(v.ym);
        frame_start_i = 1'b1;
        prei_q.delete();
        posi_q.delete();
        for (int y = 0; y <= v.ym; y++)
            for (int x = 0; x <= v.xm; x++) begin
                prei_q.push_back({8'(x), 8'(y)});
                posi_q.push_back({8'(x), 8'(y)});
            end
        n_exp     = (v.xm + 1) * (v.ym + 1);
        prei_cnt  = 0;
        posi_cnt  = 0;
        toggles   = 0;
        stage_idx = 0;
        prev_sel  = 1'b0;
        mon_en    = 1'b1;
        tick();
        frame_start_i = 1'b0;
        ctu_x_max_i   = XW'($urandom_range(0, 255));
        ctu_y_max_i   = YW'($urandom_range(0, 255));
        chk("start_err_clr", 64'(err_o), 64'(0));
        chk("start_busy", 64'(busy_o), 64'(1));
        stage = 0;
        for (int guard = 0; guard < 64; guard++) begin
            p = prei_start_o;
            q = posi_start_o;
            if (!(p || q)) begin
                chk("stage_start", 64'(p | q), 64'(1));
                break;
            end
            if (v.abort == stage) begin
                tick();
                #2 rst = 1'b1;
                #1 chk("rst_async_outs", all_outs(), 64'(0));
                mon_en = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                nd = 1'b0;
                for (int i = 0; i < 6; i++) begin
                    tick();
                    nd = nd | frame_done_o;
                end
                chk("abort_no_done", 64'(nd), 64'(0));
                chk("abort_idle", all_outs(), 64'(0));
                return;
            end
            lat_p   = (v.lat_p > 0) ? v.lat_p : int'($urandom_range(1, 6));
            lat_q   = (v.lat_q > 0) ? v.lat_q : int'($urandom_range(1, 6));
            dup_now = (v.dup != 0) && (stage == 1);
            if (dup_now) lat_q = lat_p + 3;
            tmax = 0;
            if (p && lat_p > tmax) tmax = lat_p;
            if (q && lat_q > tmax) tmax = lat_q;
            for (int t = 1; t <= tmax; t++) begin
                tick();
                prei_done_i   = p && ((t == lat_p) || (dup_now && t == lat_p + 1));
                posi_done_i   = q && (t == lat_q);
                frame_start_i = (v.poke != 0) && (stage == 2) && (t == 1);
            end
            tick();
            prei_done_i   = 1'b0;
            posi_done_i   = 1'b0;
            frame_start_i = 1'b0;
            tick();
            chk("stage_gap", 64'(prei_start_o | posi_start_o | frame_done_o), 64'(1));
            for (int w = 0; w < 50 && !(prei_start_o || posi_start_o || frame_done_o); w++)
                tick();
            stage++;
            if (frame_done_o) break;
        end
        chk("frame_done_seen", 64'(frame_done_o), 64'(1));
        chk("done_busy", 64'(busy_o), 64'(1));
        chk("prei_starts", 64'(prei_cnt), 64'(v.exp_starts));
        chk("posi_starts", 64'(posi_cnt), 64'(v.exp_starts));
        chk("sel_toggles", 64'(toggles), 64'(v.exp_toggles));
        chk("done_sel", 64'(sel_mod_2_o), 64'(v.exp_toggles % 2));
        chk("err_end", 64'(err_o), 64'(v.exp_err));
        mon_en = 1'b0;
        tick();
        chk("done_pulse", 64'(frame_done_o), 64'(0));
        chk("busy_fall", 64'(busy_o), 64'(0));
    endtask

    initial begin
        vec_t rv;
        int   n;
        //          xm ym lp  lq dup poke abort starts toggles err
        tbl[0] = '{1,  0, 10, 20, 0,  0,  -1,   2,     3,      0};
        tbl[1] = '{0,  0, 0,  0,  0,  0,  -1,   1,     2,      0};
        tbl[2] = '{1,  1, 3,  3,  0,  0,  -1,   4,     5,      0};
        tbl[3] = '{2,  1, 0,  0,  0,  1,  -1,   6,     7,      0};
        tbl[4] = '{1,  0, 2,  0,  1,  0,  -1,   2,     3,      1};
        tbl[5] = '{2,  1, 0,  0,  0,  0,   2,   6,     7,      0};
        tbl[6] = '{1,  1, 0,  0,  0,  0,  -1,   4,     5,      0};

        repeat (3) @(negedge clk);
        chk("reset_outs", all_outs(), 64'(0));
        rst = 1'b0;
        tick();
        chk("idle_outs", all_outs(), 64'(0));

        for (int i = 0; i < 7; i++) begin
            if (i == 1) begin
                tick();
                prei_done_i = 1'b1;
                tick();
                prei_done_i = 1'b0;
                tick();
                chk("idle_spurious_err", 64'(err_o), 64'(1));
                chk("idle_spurious_busy", 64'(busy_o), 64'(0));
            end
            run_frame(tbl[i]);
        end

        for (int r = 0; r < 12; r++) begin
            rv = '0;
            rv.xm = int'($urandom_range(0, 3));
            rv.ym = int'($urandom_range(0, 2));
            rv.abort = -1;
            n = (rv.xm + 1) * (rv.ym + 1);
            rv.exp_starts  = n;
            rv.exp_toggles = n + 1;
            run_frame(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
